sirv_ncyc_sram_ctrl: RTL and testbench

Parametrised N-cycle SRAM access controller, the successor of the single-cycle TCM SRAM controller. It sits between an ITCM/DTCM user-op channel and a synchronous SRAM macro whose read latency is a configurable RD_LAT cycles. It tracks in-flight accesses with a credit counter and buffers returning read data in a response FIFO, so that uop_rsp_ready backpressure never loses data and ordering is preserved. It gates the RAM clock with the standard clock-gate cell.

---
 rtl/sirv_ncyc_sram_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_sirv_ncyc_sram_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sirv_ncyc_sram_ctrl.sv
// N-cycle SRAM access controller: credit-limited command issue, RD_LAT-deep
// latency pipe that tracks in-flight accesses, and an in-order response FIFO
// that catches ram_dout when the response channel is back-pressured.
//
// Handshake: a transfer happens on a channel in any cycle where valid and
// ready are both high at the rising edge of clk. Once valid is raised, the
// source holds valid and its payload stable until the transfer happens.
// Ready is allowed to depend on valid, but never the other way round.

// Latch-based clock gate: the enable is captured while clk is low, so
// clk_out has no glitches.
module sirv_clkgate (
  input  logic clk_in,
  input  logic test_mode,
  input  logic clock_en,
  output logic clk_out
);
  logic en_lat;

  // Transparent while the clock is low, holds while it is high
  always_latch begin
    if (!clk_in) en_lat = clock_en | test_mode;
  end

  assign clk_out = clk_in & en_lat;
endmodule

module sirv_ncyc_sram_ctrl #(
  parameter int DW        = 32,
  parameter int MW        = 4,
  parameter int AW        = 32,
  parameter int AW_LSB    = 3,
  parameter int USR_W     = 3,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 sram_ctrl_active,
  input  logic                 tcm_cgstop,
  input  logic                 uop_cmd_valid,
  output logic                 uop_cmd_ready,
  input  logic                 uop_cmd_read,
  input  logic [AW-1:0]        uop_cmd_addr,
  input  logic [DW-1:0]        uop_cmd_wdata,
  input  logic [MW-1:0]        uop_cmd_wmask,
  input  logic [USR_W-1:0]     uop_cmd_usr,
  output logic                 uop_rsp_valid,
  input  logic                 uop_rsp_ready,
  output logic [DW-1:0]        uop_rsp_rdata,
  output logic [USR_W-1:0]     uop_rsp_usr,
  output logic                 ram_cs,
  output logic                 ram_we,
  output logic [AW-AW_LSB-1:0] ram_addr,
  output logic [MW-1:0]        ram_wem,
  output logic [DW-1:0]        ram_din,
  input  logic [DW-1:0]        ram_dout,
  output logic                 clk_ram,
  input  logic                 test_mode
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  if (RD_LAT < 1 || RD_LAT > 4 || RSP_DEPTH < 1) begin : g_param_err
    $error("sirv_ncyc_sram_ctrl: RD_LAT must be 1..4 and RSP_DEPTH >= 1");
  end

  // Outstanding-access credits (accepted but not yet handed to the user)
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cmd_acc, rsp_hsk;

  // Latency pipe, stage RD_LAT is the entry whose ram_dout arrives now
  logic             pipe_vld_q [1:RD_LAT];
  logic             pipe_rd_q  [1:RD_LAT];
  logic [USR_W-1:0] pipe_usr_q [1:RD_LAT];
  logic             pipe_any;
  logic             arr_vld;
  logic [DW-1:0]    arr_rdata;

  // Response FIFO
  logic [DW-1:0]    fifo_rdata_q [0:RSP_DEPTH-1];
  logic [USR_W-1:0] fifo_usr_q   [0:RSP_DEPTH-1];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic             fifo_ne, fifo_push, fifo_pop;
  logic             clk_en;
  logic             unused_addr_lsb;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready only depends on registered credits, never on uop_rsp_ready
  assign uop_cmd_ready = ~rst & (cnt_q < CW'(RSP_DEPTH));
  assign cmd_acc       = uop_cmd_valid & uop_cmd_ready;

  assign ram_cs   = cmd_acc;
  assign ram_we   = cmd_acc & ~uop_cmd_read;
  assign ram_addr = uop_cmd_addr[AW-1:AW_LSB];
  assign ram_wem  = uop_cmd_wmask;
  assign ram_din  = uop_cmd_wdata;
  assign unused_addr_lsb = ^uop_cmd_addr[AW_LSB-1:0];

  assign arr_vld   = pipe_vld_q[RD_LAT];
  assign arr_rdata = pipe_rd_q[RD_LAT] ? ram_dout : '0;

  assign fifo_ne       = (fifo_cnt_q != '0);
  assign uop_rsp_valid = ~rst & (fifo_ne | arr_vld);
  assign uop_rsp_rdata = fifo_ne ? fifo_rdata_q[rd_ptr_q] : arr_rdata;
  assign uop_rsp_usr   = fifo_ne ? fifo_usr_q[rd_ptr_q] : pipe_usr_q[RD_LAT];
  assign rsp_hsk       = uop_rsp_valid & uop_rsp_ready;

  // An arriving entry bypasses only when nothing is queued and the user takes it
  assign fifo_push = arr_vld & (fifo_ne | ~uop_rsp_ready);
  assign fifo_pop  = fifo_ne & uop_rsp_ready;

  // Next-state for the credit and FIFO occupancy counters
  always_comb begin
    cnt_d = cnt_q;
    case ({cmd_acc, rsp_hsk})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    fifo_cnt_d = fifo_cnt_q;
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Credit counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Latency pipe shift register, loaded on every accepted command
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= RD_LAT; k++) pipe_vld_q[k] <= 1'b0;
    end else begin
      pipe_vld_q[1] <= cmd_acc;
      pipe_rd_q[1]  <= uop_cmd_read;
      pipe_usr_q[1] <= uop_cmd_usr;
      for (int k = 2; k <= RD_LAT; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_rd_q[k]  <= pipe_rd_q[k-1];
        pipe_usr_q[k] <= pipe_usr_q[k-1];
      end
    end
  end

  // Any pipe stage busy keeps the RAM clock running until data returns
  always_comb begin
    pipe_any = 1'b0;
    for (int k = 1; k <= RD_LAT; k++) pipe_any = pipe_any | pipe_vld_q[k];
  end

  // Response FIFO storage and pointers; reset drops everything buffered
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) begin
        fifo_rdata_q[wr_ptr_q] <= arr_rdata;
        fifo_usr_q[wr_ptr_q]   <= pipe_usr_q[RD_LAT];
        wr_ptr_q               <= ptr_inc(wr_ptr_q);
      end
      if (fifo_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign clk_en           = ram_cs | tcm_cgstop | pipe_any;
  assign sram_ctrl_active = uop_cmd_valid | (cnt_q != '0);

  sirv_clkgate u_clkgate (
    .clk_in    (clk),
    .test_mode (test_mode),
    .clock_en  (clk_en),
    .clk_out   (clk_ram)
  );
endmodule

// File: tb/tb_sirv_ncyc_sram_ctrl.sv
// Bench for sirv_ncyc_sram_ctrl: behavioural RAM with RD_LAT read latency
// (data held one cycle only), a response scoreboard and per-feature tests.
module tb_sirv_ncyc_sram_ctrl;
  localparam int DW        = 32;
  localparam int MW        = 4;
  localparam int AW        = 32;
  localparam int AW_LSB    = 3;
  localparam int USR_W     = 3;
  localparam int RD_LAT    = 2;
  localparam int RSP_DEPTH = 3;
  localparam int RAW       = AW - AW_LSB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sram_ctrl_active;
  logic              tcm_cgstop = 1'b0;
  logic              uop_cmd_valid = 1'b0;
  logic              uop_cmd_ready;
  logic              uop_cmd_read = 1'b0;
  logic [AW-1:0]     uop_cmd_addr = '0;
  logic [DW-1:0]     uop_cmd_wdata = '0;
  logic [MW-1:0]     uop_cmd_wmask = '0;
  logic [USR_W-1:0]  uop_cmd_usr = '0;
  logic              uop_rsp_valid;
  logic              uop_rsp_ready = 1'b0;
  logic [DW-1:0]     uop_rsp_rdata;
  logic [USR_W-1:0]  uop_rsp_usr;
  logic              ram_cs, ram_we;
  logic [RAW-1:0]    ram_addr;
  logic [MW-1:0]     ram_wem;
  logic [DW-1:0]     ram_din;
  logic [DW-1:0]     ram_dout;
  logic              clk_ram;
  logic              test_mode = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc = 0, n_rsp = 0;
  int first_acc = 0, last_acc = 0, first_rsp = 0, last_rsp = 0;

  logic [DW+USR_W-1:0] exp_q[$];

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sirv_ncyc_sram_ctrl #(
    .DW(DW), .MW(MW), .AW(AW), .AW_LSB(AW_LSB), .USR_W(USR_W),
    .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
  ) u_dut (
    .clk(clk), .rst(rst), .sram_ctrl_active(sram_ctrl_active),
    .tcm_cgstop(tcm_cgstop),
    .uop_cmd_valid(uop_cmd_valid), .uop_cmd_ready(uop_cmd_ready),
    .uop_cmd_read(uop_cmd_read), .uop_cmd_addr(uop_cmd_addr),
    .uop_cmd_wdata(uop_cmd_wdata), .uop_cmd_wmask(uop_cmd_wmask),
    .uop_cmd_usr(uop_cmd_usr),
    .uop_rsp_valid(uop_rsp_valid), .uop_rsp_ready(uop_rsp_ready),
    .uop_rsp_rdata(uop_rsp_rdata), .uop_rsp_usr(uop_rsp_usr),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout),
    .clk_ram(clk_ram), .test_mode(test_mode)
  );

  // RAM model: 16 words, read data valid RD_LAT cycles after cs, then junk
  logic [DW-1:0] mem [16];
  logic [DW-1:0] rd_pipe [1:RD_LAT];
  logic          mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= $urandom;
      mem_init <= 1'b1;
    end else if (ram_cs && ram_we) begin
      for (int b = 0; b < MW; b++)
        if (ram_wem[b]) mem[ram_addr[3:0]][8*b +: 8] <= ram_din[8*b +: 8];
    end
    for (int k = RD_LAT; k >= 2; k--) rd_pipe[k] <= rd_pipe[k-1];
    rd_pipe[1] <= (ram_cs && !ram_we) ? mem[ram_addr[3:0]] : $urandom;
  end
  assign ram_dout = rd_pipe[RD_LAT];

  // Scoreboard: push on accepted command, pop on response handshake
  always @(negedge clk) begin
    logic [DW+USR_W-1:0] exp;
    if (!rst) begin
      if (uop_rsp_valid && uop_rsp_ready) begin
        n_checks++;
        if (n_rsp == 0) first_rsp = cyc;
        last_rsp = cyc;
        n_rsp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected got rdata=%h usr=%0d required no response",
                   uop_rsp_rdata, uop_rsp_usr);
        end else begin
          exp = exp_q.pop_front();
          if ({uop_rsp_rdata, uop_rsp_usr} !== exp) begin
            n_fail++;
            $display("FAIL rsp_data got rdata=%h usr=%0d required rdata=%h usr=%0d",
                     uop_rsp_rdata, uop_rsp_usr, exp[DW+USR_W-1:USR_W], exp[USR_W-1:0]);
          end
        end
      end
      if (uop_cmd_valid && uop_cmd_ready) begin
        exp_q.push_back(uop_cmd_read ? {mem[uop_cmd_addr[6:3]], uop_cmd_usr}
                                     : {{DW{1'b0}}, uop_cmd_usr});
        if (n_acc == 0) first_acc = cyc;
        last_acc = cyc;
        n_acc++;
      end
    end
  end

  // Driver tasks
  task automatic send_cmd(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [MW-1:0] wm, input logic [USR_W-1:0] u);
    int budget = 0;
    uop_cmd_valid = 1'b1; uop_cmd_read = rd; uop_cmd_addr = a;
    uop_cmd_wdata = wd;   uop_cmd_wmask = wm; uop_cmd_usr = u;
    @(negedge clk);
    while (!uop_cmd_ready && budget < 50) begin budget++; @(negedge clk); end
    if (!uop_cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept_timeout got ready=0 required ready=1 within 50 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    uop_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    uop_rsp_ready = 1'b1;
    @(negedge clk);
    while ((exp_q.size() != 0 || uop_rsp_valid) && budget < 100) begin budget++; @(negedge clk); end
    if (exp_q.size() != 0 || uop_rsp_valid) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout got pending=%0d required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    uop_cmd_valid = 1'b1; uop_cmd_read = 1'b1; uop_cmd_addr = 32'h10;
    repeat (3) @(negedge clk);
    n_checks++; if (uop_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready got %b required 0", uop_cmd_ready); end
    n_checks++; if (uop_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b required 0", uop_rsp_valid); end
    n_checks++; if (ram_cs !== 1'b0) begin n_fail++; $display("FAIL rst_ram_cs got %b required 0", ram_cs); end
    @(posedge clk); #1;
    uop_cmd_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (uop_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %b required 1", uop_cmd_ready); end
    n_checks++; if (sram_ctrl_active !== 1'b0) begin n_fail++; $display("FAIL post_rst_active got %b required 0", sram_ctrl_active); end
    n_checks++; if (uop_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_rsp_valid got %b required 0", uop_rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    int lat;
    logic [DW-1:0] exp_data;
    uop_rsp_ready = 1'b1;
    uop_cmd_valid = 1'b1; uop_cmd_read = 1'b1; uop_cmd_addr = 32'h0000_0048; uop_cmd_usr = 3'd5;
    @(negedge clk);
    exp_data = mem[9];
    n_checks++; if (ram_cs !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL single_cs got cs=%b we=%b required cs=1 we=0", ram_cs, ram_we); end
    n_checks++; if (ram_addr !== RAW'(9)) begin n_fail++; $display("FAIL single_addr got %h required 9", ram_addr); end
    @(posedge clk); #1;
    idle();
    lat = 1;
    @(negedge clk);
    while (!uop_rsp_valid && lat < 10) begin lat++; @(negedge clk); end
    n_checks++; if (lat !== RD_LAT) begin n_fail++; $display("FAIL single_latency got %0d required %0d", lat, RD_LAT); end
    n_checks++; if (uop_rsp_rdata !== exp_data || uop_rsp_usr !== 3'd5) begin
      n_fail++; $display("FAIL single_rsp got %h/%0d required %h/5", uop_rsp_rdata, uop_rsp_usr, exp_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (sram_ctrl_active !== 1'b0 || uop_cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_idle got active=%b ready=%b required active=0 ready=1", sram_ctrl_active, uop_cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int budget = 0;
    n_acc = 0; n_rsp = 0;
    uop_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      send_cmd(1'b1, AW'($urandom_range(0, 127)), '0, '0, USR_W'(i));
    idle();
    while (n_rsp < 8 && budget < 30) begin budget++; @(negedge clk); end
    n_checks++; if (n_acc !== 8 || last_acc - first_acc !== 7) begin
      n_fail++; $display("FAIL b2b_accept got n=%0d span=%0d required n=8 span=7", n_acc, last_acc - first_acc);
    end
    n_checks++; if (n_rsp !== 8 || last_rsp - first_rsp !== 7) begin
      n_fail++; $display("FAIL b2b_rsp got n=%0d span=%0d required n=8 span=7", n_rsp, last_rsp - first_rsp);
    end
    n_checks++; if (first_rsp - first_acc !== RD_LAT) begin
      n_fail++; $display("FAIL b2b_latency got %0d required %0d", first_rsp - first_acc, RD_LAT);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int budget = 0;
    logic seen_ready = 1'b0;
    n_acc = 0;
    uop_rsp_ready = 1'b0;
    for (int i = 0; i < RSP_DEPTH; i++)
      send_cmd(1'b1, AW'(8 * i + 8), '0, '0, USR_W'(i + 1));
    uop_cmd_valid = 1'b1; uop_cmd_read = 1'b1; uop_cmd_addr = 32'h60; uop_cmd_usr = 3'd7;
    repeat (6) begin @(negedge clk); seen_ready = seen_ready | uop_cmd_ready; end
    n_checks++; if (seen_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready got 1 required 0 while credits exhausted"); end
    n_checks++; if (n_acc !== RSP_DEPTH) begin n_fail++; $display("FAIL bp_accepted got %0d required %0d", n_acc, RSP_DEPTH); end
    n_checks++; if (uop_rsp_valid !== 1'b1 || {uop_rsp_rdata, uop_rsp_usr} !== exp_q[0]) begin
      n_fail++; $display("FAIL bp_head got v=%b %h/%0d required v=1 %h", uop_rsp_valid, uop_rsp_rdata, uop_rsp_usr, exp_q[0]);
    end
    n_checks++; if (sram_ctrl_active !== 1'b1) begin n_fail++; $display("FAIL bp_active got %b required 1", sram_ctrl_active); end
    @(posedge clk); #1;
    uop_rsp_ready = 1'b1;
    @(negedge clk);
    while (!uop_cmd_ready && budget < 20) begin budget++; @(negedge clk); end
    @(posedge clk); #1;
    send_cmd(1'b1, 32'h68, '0, '0, 3'd6);
    idle();
    drain();
    n_checks++; if (n_acc !== RSP_DEPTH + 2) begin n_fail++; $display("FAIL bp_total got %0d required %0d", n_acc, RSP_DEPTH + 2); end
  endtask

  task automatic test_write();
    logic [DW-1:0] old, merged;
    logic got_w = 1'b0, got_r = 1'b0;
    uop_rsp_ready = 1'b1;
    old = mem[5];
    merged = {old[31:24], 8'hA5, old[15:8], 8'h34};
    uop_cmd_valid = 1'b1; uop_cmd_read = 1'b0; uop_cmd_addr = 32'h28;
    uop_cmd_wdata = 32'hA5A5_1234; uop_cmd_wmask = 4'b0101; uop_cmd_usr = 3'd3;
    @(negedge clk);
    n_checks++; if (ram_cs !== 1'b1 || ram_we !== 1'b1) begin n_fail++; $display("FAIL wr_cs_we got cs=%b we=%b required 1/1", ram_cs, ram_we); end
    n_checks++; if (ram_wem !== 4'b0101 || ram_din !== 32'hA5A5_1234) begin
      n_fail++; $display("FAIL wr_fields got wem=%b din=%h required 0101/a5a51234", ram_wem, ram_din);
    end
    @(posedge clk); #1;
    send_cmd(1'b1, 32'h28, '0, '0, 3'd6);
    idle();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (uop_rsp_valid && uop_rsp_usr == 3'd3) begin
        got_w = 1'b1;
        n_checks++; if (uop_rsp_rdata !== '0) begin n_fail++; $display("FAIL wr_rsp_rdata got %h required 0", uop_rsp_rdata); end
      end
      if (uop_rsp_valid && uop_rsp_usr == 3'd6) begin
        got_r = 1'b1;
        n_checks++; if (uop_rsp_rdata !== merged) begin n_fail++; $display("FAIL wr_readback got %h required %h", uop_rsp_rdata, merged); end
      end
    end
    n_checks++; if (!(got_w && got_r)) begin n_fail++; $display("FAIL wr_rsp_seen got w=%b r=%b required 1/1", got_w, got_r); end
    @(posedge clk); #1;
  endtask

  task automatic test_clock_gate();
    logic seen_hi = 1'b0;
    tcm_cgstop = 1'b0; test_mode = 1'b0;
    repeat (2) @(posedge clk);
    repeat (3) begin @(posedge clk); #1; seen_hi = seen_hi | clk_ram; end
    n_checks++; if (seen_hi !== 1'b0) begin n_fail++; $display("FAIL cg_idle got toggling required clk_ram=0"); end
    tcm_cgstop = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (clk_ram !== 1'b1) begin n_fail++; $display("FAIL cg_cgstop got %b required 1", clk_ram); end
    tcm_cgstop = 1'b0; test_mode = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (clk_ram !== 1'b1) begin n_fail++; $display("FAIL cg_test_mode_hi got %b required 1", clk_ram); end
    @(negedge clk); #1;
    n_checks++; if (clk_ram !== 1'b0) begin n_fail++; $display("FAIL cg_test_mode_lo got %b required 0", clk_ram); end
    test_mode = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (clk_ram !== 1'b0) begin n_fail++; $display("FAIL cg_off got %b required 0", clk_ram); end
    uop_rsp_ready = 1'b1;
    uop_cmd_valid = 1'b1; uop_cmd_read = 1'b1; uop_cmd_addr = 32'h18; uop_cmd_usr = 3'd2;
    @(posedge clk); #1;
    idle();
    n_checks++; if (clk_ram !== 1'b1) begin n_fail++; $display("FAIL cg_access got %b required 1", clk_ram); end
    drain();
  endtask

  task automatic test_reset_midflight();
    logic seen_v = 1'b0;
    uop_rsp_ready = 1'b0;
    send_cmd(1'b1, 32'h20, '0, '0, 3'd1);
    send_cmd(1'b1, 32'h30, '0, '0, 3'd2);
    idle();
    @(posedge clk); #1;
    rst = 1'b1; uop_cmd_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (uop_rsp_valid !== 1'b0 || uop_cmd_ready !== 1'b0 || ram_cs !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst got v=%b rdy=%b cs=%b required 0/0/0", uop_rsp_valid, uop_cmd_ready, ram_cs);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; uop_cmd_valid = 1'b0; uop_rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (uop_cmd_ready !== 1'b1 || sram_ctrl_active !== 1'b0) begin
      n_fail++; $display("FAIL mid_after got rdy=%b active=%b required 1/0", uop_cmd_ready, sram_ctrl_active);
    end
    seen_v = uop_rsp_valid;
    repeat (6) begin @(negedge clk); seen_v = seen_v | uop_rsp_valid; end
    n_checks++; if (seen_v !== 1'b0) begin n_fail++; $display("FAIL mid_stale got rsp_valid=1 required 0"); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int sent = 0;
    logic acc = 1'b0;
    for (int c = 0; c < 600 && sent < 40; c++) begin
      @(posedge clk); #1;
      if (acc) uop_cmd_valid = 1'b0;
      uop_rsp_ready = 1'($urandom_range(0, 1));
      if (!uop_cmd_valid && $urandom_range(0, 3) != 0) begin
        uop_cmd_valid = 1'b1;
        uop_cmd_read  = 1'($urandom_range(0, 2) != 0);
        uop_cmd_addr  = AW'($urandom_range(0, 127));
        uop_cmd_wdata = $urandom;
        uop_cmd_wmask = MW'($urandom_range(0, 15));
        uop_cmd_usr   = USR_W'($urandom_range(0, 7));
      end
      @(negedge clk);
      acc = uop_cmd_valid & uop_cmd_ready;
      if (acc) sent++;
    end
    @(posedge clk); #1;
    idle();
    drain();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_backpressure();
    test_write();
    test_clock_gate();
    test_reset_midflight();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_expected got %0d required 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
